// File: rtl/wormhole_out_allocator.sv
// Wormhole output allocator: round-robin head arbitration, lock until tail, credit-gated grants.
// Grant 1 cycle after lock; no grant while credit_cnt == 0 or owner has no flit.
module wormhole_out_allocator #(
   parameter int CREDITS = 4,
   parameter int CW      = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [4:0]    req,
   input  logic [4:0]    tail,
   input  logic          credit_in,
   output logic [4:0]    grant,
   output logic [4:0]    xbar_sel,
   output logic          valid_out,
   output logic [CW-1:0] credit_cnt,
   output logic          busy,
   output logic          err_ovf
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t        state_q, state_d;
   logic [2:0]    owner_q, owner_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [CW-1:0] credit_q, credit_d;
   logic          err_q, err_d;

   logic [9:0]    req_dbl;
   logic [9:0]    req_rot_full;
   logic [4:0]    req_rot;
   logic [2:0]    first_j;
   logic [3:0]    pick_sum;
   logic [2:0]    pick;
   logic [4:0]    owner_oh;
   logic          locked;
   logic          send;
   logic          credit_full;

   // Rotate req so bit 0 is the current priority pointer, then take the lowest set bit.
   always_comb begin
      req_dbl      = {req, req};
      req_rot_full = req_dbl >> ptr_q;
      req_rot      = req_rot_full[4:0];
      first_j      = 3'd0;
      for (int j = 4; j >= 0; j--) begin
         if (req_rot[j]) first_j = 3'(j);
      end
      pick_sum = {1'b0, ptr_q} + {1'b0, first_j};
      pick     = (pick_sum >= 4'd5) ? 3'(pick_sum - 4'd5) : pick_sum[2:0];
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      ptr_d       = ptr_q;
      credit_d    = credit_q;
      err_d       = err_q;
      locked      = (state_q == LOCKED);
      owner_oh    = 5'b00001 << owner_q;
      credit_full = (credit_q == CW'(CREDITS));
      send        = locked && req[owner_q] && (credit_q != '0);

      case (state_q)
         IDLE: begin
            if (req != 5'b0) begin
               owner_d = pick;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (send && tail[owner_q]) begin
               state_d = IDLE;
               ptr_d   = (owner_q == 3'd4) ? 3'd0 : owner_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A returned credit with nothing leaving at a full counter is a downstream protocol error.
      if (send && !credit_in) begin
         credit_d = credit_q - 1'b1;
      end else if (credit_in && !send) begin
         if (credit_full) err_d = 1'b1;
         else             credit_d = credit_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= 3'd0;
         ptr_q    <= 3'd0;
         credit_q <= CW'(CREDITS);
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
         err_q    <= err_d;
      end
   end

   assign grant      = send ? owner_oh : 5'b0;
   assign xbar_sel   = locked ? owner_oh : 5'b0;
   assign valid_out  = send;
   assign busy       = locked;
   assign credit_cnt = credit_q;
   assign err_ovf    = err_q;

endmodule

// File: tb/tb_wormhole_out_allocator.sv
module tb_wormhole_out_allocator;
   localparam int CREDITS = 4;
   localparam int CW      = 4;

   logic          clk;
   logic          rst;
   logic [4:0]    req;
   logic [4:0]    tail;
   logic          credit_in;
   logic [4:0]    grant;
   logic [4:0]    xbar_sel;
   logic          valid_out;
   logic [CW-1:0] credit_cnt;
   logic          busy;
   logic          err_ovf;

   wormhole_out_allocator #(.CREDITS(CREDITS), .CW(CW)) dut (
      .clk(clk), .rst(rst), .req(req), .tail(tail), .credit_in(credit_in),
      .grant(grant), .xbar_sel(xbar_sel), .valid_out(valid_out),
      .credit_cnt(credit_cnt), .busy(busy), .err_ovf(err_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int grant;
      int xbar_sel;
      int valid_out;
      int credit_cnt;
      int busy;
      int err_ovf;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference state: owner -1 means output free.
   int m_owner, m_ptr, m_cred, m_err;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [4:0] r, input logic [4:0] t, input logic c,
                       input logic rs, input bit push);
      exp_t e;
      int   sending;
      req = r; tail = t; credit_in = c; rst = rs;
      sending = (m_owner >= 0 && r[m_owner] && m_cred > 0) ? 1 : 0;
      e.busy       = (m_owner >= 0) ? 1 : 0;
      e.xbar_sel   = (m_owner >= 0) ? (1 << m_owner) : 0;
      e.grant      = sending ? (1 << m_owner) : 0;
      e.valid_out  = sending;
      e.credit_cnt = m_cred;
      e.err_ovf    = m_err;
      if (push) q.push_back(e);
      if (rs) begin
         m_owner = -1; m_ptr = 0; m_cred = CREDITS; m_err = 0;
      end else begin
         if (m_owner < 0) begin
            for (int k = 0; k < 5; k++) begin
               if (m_owner < 0 && r[(m_ptr + k) % 5]) m_owner = (m_ptr + k) % 5;
            end
         end else if (sending && t[m_owner]) begin
            m_ptr   = (m_owner + 1) % 5;
            m_owner = -1;
         end
         m_cred = m_cred - sending + c;
         if (m_cred > CREDITS) begin
            m_cred = CREDITS;
            m_err  = 1;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic go(input logic [4:0] r, input logic [4:0] t, input logic c);
      step(r, t, c, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      step(5'b0, 5'b0, 1'b0, 1'b1, 1'b1);
   endtask

   // Monitor: compare every presented cycle against the queued expectation.
   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("grant",      int'(grant),      e.grant);
         chk("xbar_sel",   int'(xbar_sel),   e.xbar_sel);
         chk("valid_out",  int'(valid_out),  e.valid_out);
         chk("credit_cnt", int'(credit_cnt), e.credit_cnt);
         chk("busy",       int'(busy),       e.busy);
         chk("err_ovf",    int'(err_ovf),    e.err_ovf);
         chk("inv_onehot", int'($onehot0(grant)), 1);
         chk("inv_grant_busy", int'(grant == 5'b0 || busy), 1);
         chk("inv_sel_busy", int'((xbar_sel == 5'b0) == !busy), 1);
         chk("inv_cred_max", int'(int'(credit_cnt) <= CREDITS), 1);
      end
   end

   initial begin
      logic [4:0] r, t;
      logic       c, rs;
      m_owner = -1; m_ptr = 0; m_cred = CREDITS; m_err = 0;
      step(5'b0, 5'b0, 1'b0, 1'b1, 1'b0);
      step(5'b0, 5'b0, 1'b0, 1'b1, 1'b0);

      // 1: three-flit packet from L
      go(5'b10000, 5'b0, 1'b0);
      chk("t1_busy_lock", int'(busy), 1);
      go(5'b10000, 5'b0, 1'b0);
      go(5'b10000, 5'b0, 1'b0);
      go(5'b10000, 5'b10000, 1'b0);
      chk("t1_cred", int'(credit_cnt), 1);
      chk("t1_idle", int'(busy), 0);
      go(5'b0, 5'b0, 1'b0);

      // 2: round-robin single-flit packets
      do_reset();
      for (int i = 0; i < 12; i++) go(5'b11111, 5'b11111, 1'b1);

      // 3: credit stall on a 6-flit packet from N
      do_reset();
      go(5'b00001, 5'b0, 1'b0);
      for (int i = 0; i < 4; i++) go(5'b00001, 5'b0, 1'b0);
      chk("t3_cred_zero", int'(credit_cnt), 0);
      go(5'b00001, 5'b0, 1'b0);
      go(5'b00001, 5'b0, 1'b1);
      go(5'b00001, 5'b0, 1'b0);
      go(5'b00001, 5'b0, 1'b1);
      go(5'b00001, 5'b00001, 1'b0);

      // 4: simultaneous send/credit, then overflow
      do_reset();
      go(5'b00001, 5'b0, 1'b0);
      go(5'b00001, 5'b0, 1'b0);
      go(5'b00001, 5'b0, 1'b0);
      go(5'b00001, 5'b0, 1'b1);
      chk("t4_cred_hold", int'(credit_cnt), 2);
      go(5'b00001, 5'b00001, 1'b0);
      for (int i = 0; i < 3; i++) go(5'b0, 5'b0, 1'b1);
      chk("t4_cred_full", int'(credit_cnt), CREDITS);
      go(5'b0, 5'b0, 1'b1);
      chk("t4_err", int'(err_ovf), 1);
      chk("t4_cred_sat", int'(credit_cnt), CREDITS);
      go(5'b0, 5'b0, 1'b0);
      go(5'b0, 5'b0, 1'b0);

      // 5: lock hold while E bubbles and N requests
      do_reset();
      go(5'b00010, 5'b0, 1'b0);
      go(5'b00010, 5'b0, 1'b0);
      for (int i = 0; i < 3; i++) go(5'b00001, 5'b0, 1'b0);
      chk("t5_sel", int'(xbar_sel), 2);
      go(5'b00011, 5'b0, 1'b0);
      go(5'b00011, 5'b00010, 1'b0);
      go(5'b00001, 5'b0, 1'b0);
      chk("t5_next_owner", int'(xbar_sel), 1);
      go(5'b00001, 5'b00001, 1'b1);

      // 6: reset while locked with one credit left
      do_reset();
      go(5'b00100, 5'b0, 1'b0);
      for (int i = 0; i < 3; i++) go(5'b00100, 5'b0, 1'b0);
      chk("t6_cred_one", int'(credit_cnt), 1);
      step(5'b00100, 5'b0, 1'b0, 1'b1, 1'b1);
      chk("t6_busy", int'(busy), 0);
      chk("t6_cred", int'(credit_cnt), CREDITS);
      go(5'b0, 5'b0, 1'b0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         r  = 5'($urandom_range(0, 31));
         t  = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
         c  = ($urandom_range(0, 9) < 4);
         rs = ($urandom_range(0, 199) == 0);
         step(r, t, c, rs, 1'b1);
      end

      go(5'b0, 5'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
